// File: rtl/seq_signed_divider.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | seq_signed_divider : restoring 64-bit DIV/DIVU/REM/REMU, 1 bit per clock   |
// | Revision: 1.0                                                              |
// +--------------------------------------------------------------------------+

module opposite #(
    parameter int WIDTH = 64
) (
    input  logic [WIDTH-1:0] a,
    output logic [WIDTH-1:0] y
);
    assign y = ~a + WIDTH'(1);
endmodule

module seq_signed_divider #(
    parameter int WORDSIZE = 64
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                start,
    input  logic                is_signed,
    input  logic [WORDSIZE-1:0] dividend,
    input  logic [WORDSIZE-1:0] divisor,
    output logic                busy,
    output logic                done,
    output logic [WORDSIZE-1:0] quotient,
    output logic [WORDSIZE-1:0] remainder,
    output logic                div_by_zero
);
    localparam int CNT_W = (WORDSIZE > 1) ? $clog2(WORDSIZE) : 1;
    localparam logic [CNT_W-1:0]    c_last = CNT_W'(WORDSIZE - 1);
    localparam logic [WORDSIZE-1:0] c_min  = {1'b1, {(WORDSIZE-1){1'b0}}};

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_PREP = 3'd1,
        S_ITER = 3'd2,
        S_FIX  = 3'd3,
        S_DONE = 3'd4
    } state_t;

    state_t              r_state;
    state_t              w_next_state;
    logic                r_is_signed;
    logic [WORDSIZE-1:0] r_dividend;
    logic [WORDSIZE-1:0] r_divisor;
    logic [WORDSIZE-1:0] r_dvd;
    logic [WORDSIZE-1:0] r_rem;
    logic [WORDSIZE-1:0] r_dsr_mag;
    logic [CNT_W-1:0]    r_count;

    logic [WORDSIZE-1:0] w_dividend_neg;
    logic [WORDSIZE-1:0] w_divisor_neg;
    logic [WORDSIZE-1:0] w_q_neg;
    logic [WORDSIZE-1:0] w_r_neg;
    logic                w_dvd_negative;
    logic                w_dsr_negative;
    logic                w_div_zero;
    logic                w_overflow;
    logic [WORDSIZE:0]   w_rem_sh;
    logic [WORDSIZE:0]   w_diff;
    logic                w_borrow;

    opposite #(.WIDTH(WORDSIZE)) u_neg_dividend (.a(r_dividend), .y(w_dividend_neg));
    opposite #(.WIDTH(WORDSIZE)) u_neg_divisor  (.a(r_divisor),  .y(w_divisor_neg));
    opposite #(.WIDTH(WORDSIZE)) u_neg_quot     (.a(r_dvd),      .y(w_q_neg));
    opposite #(.WIDTH(WORDSIZE)) u_neg_rem      (.a(r_rem),      .y(w_r_neg));

    assign w_dvd_negative = r_is_signed & r_dividend[WORDSIZE-1];
    assign w_dsr_negative = r_is_signed & r_divisor[WORDSIZE-1];
    assign w_div_zero     = (r_divisor == '0);
    assign w_overflow     = r_is_signed & (r_dividend == c_min) & (r_divisor == '1);

    // Shifted remainder can reach 2*divisor-1; bit WORDSIZE of the difference
    // is set exactly when the trial subtraction borrows.
    assign w_rem_sh = {r_rem, r_dvd[WORDSIZE-1]};
    assign w_diff   = w_rem_sh - {1'b0, r_dsr_mag};
    assign w_borrow = w_diff[WORDSIZE];

    assign busy = (r_state == S_PREP) || (r_state == S_ITER) || (r_state == S_FIX);
    assign done = (r_state == S_DONE);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_comb begin
        w_next_state = r_state;
        case (r_state)
            S_IDLE: if (start) w_next_state = S_PREP;
            S_PREP: w_next_state = (w_div_zero || w_overflow) ? S_DONE : S_ITER;
            S_ITER: if (r_count == c_last) w_next_state = S_FIX;
            S_FIX:  w_next_state = S_DONE;
            S_DONE: w_next_state = S_IDLE;
            default: w_next_state = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_is_signed <= 1'b0;
            r_dividend  <= '0;
            r_divisor   <= '0;
            r_dvd       <= '0;
            r_rem       <= '0;
            r_dsr_mag   <= '0;
            r_count     <= '0;
            quotient    <= '0;
            remainder   <= '0;
            div_by_zero <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        r_is_signed <= is_signed;
                        r_dividend  <= dividend;
                        r_divisor   <= divisor;
                        div_by_zero <= 1'b0;
                    end
                end
                S_PREP: begin
                    if (w_div_zero) begin
                        quotient    <= '1;
                        remainder   <= r_dividend;
                        div_by_zero <= 1'b1;
                    end else if (w_overflow) begin
                        quotient  <= r_dividend;
                        remainder <= '0;
                    end else begin
                        r_dvd     <= w_dvd_negative ? w_dividend_neg : r_dividend;
                        r_dsr_mag <= w_dsr_negative ? w_divisor_neg : r_divisor;
                        r_rem     <= '0;
                        r_count   <= '0;
                    end
                end
                S_ITER: begin
                    r_rem   <= w_borrow ? w_rem_sh[WORDSIZE-1:0] : w_diff[WORDSIZE-1:0];
                    r_dvd   <= {r_dvd[WORDSIZE-2:0], ~w_borrow};
                    r_count <= r_count + CNT_W'(1);
                end
                S_FIX: begin
                    quotient  <= (w_dvd_negative ^ w_dsr_negative) ? w_q_neg : r_dvd;
                    remainder <= w_dvd_negative ? w_r_neg : r_rem;
                end
                default: ;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_seq_signed_divider.sv
`default_nettype none
// Self-checking bench for seq_signed_divider: directed table, corner sequences, random vs. model.
module tb_seq_signed_divider;
    localparam int W = 64;
    localparam logic [W-1:0] ONES = '1;
    localparam logic [W-1:0] MIN  = {1'b1, {(W-1){1'b0}}};

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         start = 1'b0;
    logic         is_signed = 1'b0;
    logic [W-1:0] dividend = '0;
    logic [W-1:0] divisor = '0;
    logic         busy, done, div_by_zero;
    logic [W-1:0] quotient, remainder;

    int total = 0;
    int bad = 0;

    seq_signed_divider #(.WORDSIZE(W)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .is_signed(is_signed),
        .dividend(dividend), .divisor(divisor), .busy(busy), .done(done),
        .quotient(quotient), .remainder(remainder), .div_by_zero(div_by_zero)
    );

    always #5 clk = ~clk;

    typedef struct {
        bit           sg;
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic [W-1:0] q;
        logic [W-1:0] r;
        bit           dz;
        int           lat;
    } vec_t;

    task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h", name, act, exp);
        end
    endtask

    // RISC-V M-extension division rules in plain arithmetic.
    task automatic model(input bit sg, input logic [W-1:0] a, input logic [W-1:0] b,
                         output logic [W-1:0] q, output logic [W-1:0] r,
                         output bit dz, output int lat);
        logic signed [W-1:0] sa, sb;
        sa = a;
        sb = b;
        dz = 1'b0;
        lat = 67;
        if (b == '0) begin
            q = ONES; r = a; dz = 1'b1; lat = 2;
        end else if (sg && a == MIN && b == ONES) begin
            q = a; r = '0; lat = 2;
        end else if (sg) begin
            q = sa / sb; r = sa % sb;
        end else begin
            q = a / b; r = a % b;
        end
    endtask

    // Start is sampled at the next rising edge (cycle 0); returns the cycle of done.
    task automatic run_op(input bit sg, input logic [W-1:0] a, input logic [W-1:0] b, input bit hold,
                          output logic [W-1:0] q, output logic [W-1:0] r, output logic dz,
                          output int lat, output int perr);
        logic [W-1:0] q_prev, r_prev;
        q_prev = quotient;
        r_prev = remainder;
        q = '0; r = '0; dz = 1'b0; lat = -1; perr = 0;
        @(posedge clk); #1;
        start = 1'b1; is_signed = sg; dividend = a; divisor = b;
        for (int n = 1; n <= 100; n++) begin
            @(posedge clk); #1;
            if (hold) begin
                is_signed = 1'($urandom);
                dividend  = {$urandom, $urandom};
                divisor   = {$urandom, $urandom};
            end else begin
                start = 1'b0;
            end
            @(negedge clk);
            if (done) begin
                start = 1'b0;
                if (busy) perr++;
                lat = n; q = quotient; r = remainder; dz = div_by_zero;
                break;
            end
            if (!busy) perr++;
            if (n == 1 && div_by_zero !== 1'b0) perr++;
            if (quotient !== q_prev || remainder !== r_prev) perr++;
        end
        start = 1'b0;
    endtask

    vec_t vt[8];

    initial begin
        logic [W-1:0] q, r, eq, er;
        logic         dz;
        bit           edz, sg;
        int           lat, elat, perr, extra;
        logic [W-1:0] a, b;

        vt[0] = '{0, 64'd100, 64'd7, 64'd14, 64'd2, 0, 67};
        vt[1] = '{1, 64'hFFFF_FFFF_FFFF_FFF9, 64'd2, 64'hFFFF_FFFF_FFFF_FFFD, ONES, 0, 67};
        vt[2] = '{0, 64'hFFFF_FFFF_FFFF_FFF9, 64'd2, 64'h7FFF_FFFF_FFFF_FFFC, 64'd1, 0, 67};
        vt[3] = '{1, 64'd5, 64'd0, ONES, 64'd5, 1, 2};
        vt[4] = '{1, MIN, ONES, MIN, 64'd0, 0, 2};
        vt[5] = '{0, MIN, ONES, 64'd0, MIN, 0, 67};
        vt[6] = '{0, 64'd0, 64'd0, ONES, 64'd0, 1, 2};
        vt[7] = '{1, 64'hFFFF_FFFF_FFFF_FF9C, 64'hFFFF_FFFF_FFFF_FFF9, 64'd14,
                  64'hFFFF_FFFF_FFFF_FFFE, 0, 67};

        repeat (2) @(posedge clk);
        #2;
        check("reset_busy", W'(busy), '0);
        check("reset_done", W'(done), '0);
        check("reset_q", quotient, '0);
        check("reset_r", remainder, '0);
        check("reset_dz", W'(div_by_zero), '0);
        @(negedge clk);
        rst_n = 1'b1;

        for (int i = 0; i < 8; i++) begin
            run_op(vt[i].sg, vt[i].a, vt[i].b, 1'b0, q, r, dz, lat, perr);
            check($sformatf("vec%0d_q", i), q, vt[i].q);
            check($sformatf("vec%0d_r", i), r, vt[i].r);
            check($sformatf("vec%0d_dz", i), W'(dz), W'(vt[i].dz));
            check($sformatf("vec%0d_lat", i), W'(lat), W'(vt[i].lat));
            check($sformatf("vec%0d_protocol", i), W'(perr), '0);
        end

        // start held high with operands changing while busy
        run_op(1'b0, 64'hBA21, 64'h10, 1'b1, q, r, dz, lat, perr);
        check("hold_q", q, 64'hBA2);
        check("hold_r", r, 64'd1);
        check("hold_lat", W'(lat), W'(67));
        check("hold_protocol", W'(perr), '0);
        extra = 0;
        repeat (4) begin
            @(negedge clk);
            if (done || busy) extra++;
        end
        check("hold_single_done", W'(extra), '0);

        // asynchronous reset in the middle of an operation
        @(posedge clk); #1;
        start = 1'b1; is_signed = 1'b0; dividend = ONES; divisor = 64'd3;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (19) @(posedge clk);
        #3;
        rst_n = 1'b0;
        #1;
        check("midreset_busy", W'(busy), '0);
        check("midreset_done", W'(done), '0);
        check("midreset_q", quotient, '0);
        check("midreset_r", remainder, '0);
        check("midreset_dz", W'(div_by_zero), '0);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        extra = 0;
        repeat (80) begin
            @(negedge clk);
            if (done || busy) extra++;
        end
        check("midreset_no_done", W'(extra), '0);
        run_op(1'b0, ONES, 64'd3, 1'b0, q, r, dz, lat, perr);
        check("after_reset_q", q, 64'h5555_5555_5555_5555);
        check("after_reset_r", r, 64'd0);
        check("after_reset_lat", W'(lat), W'(67));

        // randomized operations against the reference model
        for (int i = 0; i < 40; i++) begin
            sg = 1'($urandom);
            a = {$urandom, $urandom} >> $urandom_range(0, 63);
            if ($urandom_range(0, 1) == 1) a = -a;
            case ($urandom_range(0, 9))
                0: b = '0;
                1: b = W'($urandom_range(1, 20));
                2: begin a = MIN; b = ONES; end
                3: b = -W'($urandom_range(1, 20));
                default: b = {$urandom, $urandom} >> $urandom_range(0, 63);
            endcase
            model(sg, a, b, eq, er, edz, elat);
            run_op(sg, a, b, 1'b0, q, r, dz, lat, perr);
            check($sformatf("rnd%0d_q", i), q, eq);
            check($sformatf("rnd%0d_r", i), r, er);
            check($sformatf("rnd%0d_dz", i), W'(dz), W'(edz));
            check($sformatf("rnd%0d_lat", i), W'(lat), W'(elat));
            check($sformatf("rnd%0d_protocol", i), W'(perr), '0);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end
endmodule
`default_nettype wire
